// File: rtl/param_processor.sv
// param_processor: parametrised multi-cycle compute core.
// Eight DATA_W-bit registers, a writable 2^PC_W-word instruction memory,
// an internal program counter with branches, and a HALT instruction.
// Each instruction walks FETCH -> DECODE -> EXEC -> WB. Dropping run pauses
// the core in IDLE at the next instruction boundary.
// Optional feature: define PARAM_PROC_MUL_EN to turn opcode E into an
// unsigned multiply. When it is undefined, opcode E is a NOP.
// Handshake: there is no valid/ready pair. run is a level. It is sampled in
// IDLE to start execution and in WB to decide whether to continue.
// imem_we is a single-cycle strobe. It is honoured only in IDLE or HALT.
module param_processor #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              imem_we,
    input  logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_wdata,
    output logic [3:0]        state,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] alu_result,
    output logic [2:0]        flags,
    output logic              halted
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_WB     = 4'd4,
        S_HALT   = 4'd5
    } state_t;

    state_t            st;
    logic [15:0]       imem [0:(1<<PC_W)-1];
    logic [DATA_W-1:0] regs [0:7];
    logic [15:0]       ir;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              wb_en;
    logic              take_br;
    logic [PC_W-1:0]   br_target;

    logic [3:0]        opc;
    logic [2:0]        rd;
    logic [2:0]        ra;
    logic [2:0]        rb;
    logic [5:0]        imm6;
    logic [DATA_W-1:0] imm_sx;
    logic [DATA_W-1:0] add_b;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] res;
    logic              c_out;
    logic              res_we;
    logic              fl_we;
    logic              br_taken;
`ifdef PARAM_PROC_MUL_EN
    logic [2*DATA_W-1:0] prod;
`endif

    assign state  = st;
    assign opc    = ir[15:12];
    assign rd     = ir[11:9];
    assign ra     = ir[8:6];
    assign rb     = ir[5:3];
    assign imm6   = ir[5:0];
    assign imm_sx = {{(DATA_W-6){imm6[5]}}, imm6};
    // ADD and ADDI share one adder. Its extra bit is the carry out.
    assign add_b  = (opc == 4'h9) ? imm_sx : op_b;
    assign sum    = {1'b0, op_a} + {1'b0, add_b};
`ifdef PARAM_PROC_MUL_EN
    assign prod   = op_a * op_b;
`endif

    // ALU: result, carry and the write/flag-update enables for the current IR.
    always_comb begin
        res    = '0;
        c_out  = 1'b0;
        res_we = 1'b0;
        fl_we  = 1'b0;
        case (opc)
            4'h1, 4'h9: begin res = sum[DATA_W-1:0]; c_out = sum[DATA_W]; res_we = 1'b1; fl_we = 1'b1; end
            4'h2: begin res = op_a - op_b; c_out = (op_a < op_b); res_we = 1'b1; fl_we = 1'b1; end
            4'h3: begin res = op_a & op_b; res_we = 1'b1; fl_we = 1'b1; end
            4'h4: begin res = op_a | op_b; res_we = 1'b1; fl_we = 1'b1; end
            4'h5: begin res = op_a ^ op_b; res_we = 1'b1; fl_we = 1'b1; end
            4'h6: begin res = {op_a[DATA_W-2:0], 1'b0}; c_out = op_a[DATA_W-1]; res_we = 1'b1; fl_we = 1'b1; end
            4'h7: begin res = {1'b0, op_a[DATA_W-1:1]}; c_out = op_a[0]; res_we = 1'b1; fl_we = 1'b1; end
            4'h8: begin res = {{(DATA_W-6){1'b0}}, imm6}; res_we = 1'b1; end
            4'hD: begin res = op_a; res_we = 1'b1; end
`ifdef PARAM_PROC_MUL_EN
            4'hE: begin
                res    = prod[DATA_W-1:0];
                c_out  = |prod[2*DATA_W-1:DATA_W];
                res_we = 1'b1;
                fl_we  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Branch decision. Branches never touch the flags, so the registered Z is current.
    assign br_taken = (opc == 4'hA) ||
                      (opc == 4'hB && flags[2]) ||
                      (opc == 4'hC && !flags[2]);

    // Instruction memory write port. It is open only while the core is parked.
    // Reset blocks the write but does not clear the contents.
    always_ff @(posedge clk) begin
        if (!rst && imem_we && (st == S_IDLE || st == S_HALT)) begin
            imem[imem_addr] <= imem_wdata;
        end
    end

    // Control FSM with the datapath registers it sequences.
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= S_IDLE;
            pc         <= '0;
            alu_result <= '0;
            flags      <= 3'b000;
            halted     <= 1'b0;
            ir         <= '0;
            op_a       <= '0;
            op_b       <= '0;
            wb_en      <= 1'b0;
            take_br    <= 1'b0;
            br_target  <= '0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (st)
                S_IDLE: begin
                    if (run) begin
                        st <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ir <= imem[pc];
                    st <= S_DECODE;
                end
                S_DECODE: begin
                    op_a <= regs[ra];
                    op_b <= regs[rb];
                    st   <= S_EXEC;
                end
                S_EXEC: begin
                    if (opc == 4'hF) begin
                        halted <= 1'b1;
                        st     <= S_HALT;
                    end else begin
                        if (res_we) begin
                            alu_result <= res;
                        end
                        if (fl_we) begin
                            flags <= {(res == '0), res[DATA_W-1], c_out};
                        end
                        wb_en     <= res_we;
                        take_br   <= br_taken;
                        br_target <= imm6[PC_W-1:0];
                        st        <= S_WB;
                    end
                end
                S_WB: begin
                    if (wb_en) begin
                        regs[rd] <= alu_result;
                    end
                    pc <= take_br ? br_target : pc + PC_W'(1);
                    st <= run ? S_FETCH : S_IDLE;
                end
                S_HALT: begin
                    st <= S_HALT;
                end
                default: begin
                    st <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/param_processor.md
# param_processor

Parametrised successor to the team's fixed-width multi-cycle `processor`. It has configurable data width and program depth. It owns an internal program counter with branches, has a writable instruction memory and a HALT instruction, and supports pause/resume through `run`. It is the top-level compute core that the processor testbenches drive directly.

## Interface
Parameters:
- DATA_W, 16, datapath and register width; must be ≥ 8.
- PC_W, 3, program-counter width; instruction memory holds 2^PC_W words; must be ≤ 6.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  start/continue execution.
- imem_we  in  1  instruction-memory write strobe.
- imem_addr  in  PC_W  write address.
- imem_wdata  in  16  instruction word.
- state  out  4  FSM state code.
- pc  out  PC_W  current program counter.
- alu_result  out  DATA_W  last registered ALU output.
- flags  out  3  {Z,N,C}.
- halted  out  1  high while in HALT.

## Operation
- 8 registers r0–r7, each DATA_W bits.
- Instruction fields: [15:12] opcode, [11:9] rd, [8:6] ra, [5:3] rb, [5:0] imm6.
- Opcodes:
  - 0 NOP.
  - 1 ADD: rd=ra+rb.
  - 2 SUB: rd=ra−rb.
  - 3 AND, 4 OR, 5 XOR.
  - 6 SHL: rd=ra<<1.
  - 7 SHR: rd=ra>>1, logical.
  - 8 LDI: rd=zero-extended imm6.
  - 9 ADDI: rd=ra+sign-extended imm6.
  - A JMP: pc=imm6[PC_W-1:0].
  - B BEQ: jump if Z=1.
  - C BNE: jump if Z=0.
  - D MOV: rd=ra.
  - E: MUL or NOP (see Configuration).
  - F HALT.
- Flag updates:
  - Only opcodes 1–7, 9 (and E when MUL is enabled) update flags.
  - Z = result==0; N = result MSB.
  - C:
    - ADD/ADDI: carry out.
    - SUB: borrow, i.e. ra<rb unsigned.
    - SHL: the bit shifted out of the MSB.
    - SHR: the bit shifted out of the LSB.
    - Logic ops: 0.
- All arithmetic is modulo 2^DATA_W. PC increments modulo 2^PC_W, so 2^PC_W−1 wraps to 0.
- FSM state codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5. Codes 6–15 are unreachable and return to IDLE on the next edge.
- Transitions:
  - IDLE→FETCH when run=1.
  - FETCH→DECODE, DECODE→EXEC, EXEC→WB unconditionally.
  - EXEC of HALT→HALT (no WB; pc is not advanced).
  - WB→FETCH if run=1; WB→IDLE if run=0 (pause on an instruction boundary).
  - HALT exits only via rst.
- Per-state actions:
  - FETCH: IR←imem[pc].
  - DECODE: operand registers←r[ra], r[rb].
  - EXEC: alu_result and flags registered; branch decision latched.
  - WB: r[rd] written for opcodes 1–9, D, E; pc←target or pc+1.
- Instruction memory writes are accepted only in IDLE or HALT and are ignored in all other states. The memory is not cleared by rst.
- Write in IDLE with run=1 on the same edge: the write takes effect and FETCH is entered. The next fetch sees the new word.
- rst on any edge wins over all other inputs, including mid-instruction. The partial instruction is discarded; no register or memory write completes.

## Timing
- Reset values: state=0, pc=0, alu_result=0, flags=000, halted=0, r0–r7=0.
- Every non-HALT instruction takes 4 cycles.
- alu_result and flags are visible the cycle after EXEC. The register write is visible to the next instruction's DECODE.
- From run rising in IDLE: first FETCH in the next cycle.
- halted is asserted the cycle after HALT's EXEC.
- A branch target is the next pc fetched; there are no delay slots.

## Configuration
- PARAM_PROC_MUL_EN defined: opcode E = MUL.
  - rd = low DATA_W bits of ra*rb, unsigned.
  - Z and N from the result; C=1 if the high half is nonzero.
  - Still 4 cycles.
- Undefined: opcode E behaves exactly as NOP. Flags and registers are unchanged, and no multiplier is synthesised.

## Test plan
- LDI r1,5; LDI r2,3; ADD r3,r1,r2 with run=1 → after cycle 12, alu_result=8, flags=000, pc=3.
- SUB r3,r2,r1 with r2=3, r1=5 → alu_result=0xFFFE, flags=011. Then SUB r4,r1,r1 → alu_result=0, flags=100.
- PC_W=3, eight NOPs → pc steps through 0..7 then returns to 0. BNE to address 2 with Z=0 → next pc=2. BEQ with Z=0 → pc+1.
- Drop run during DECODE of the instruction at pc=1 → the instruction completes, state=0, pc=2. Raise run again → execution resumes at pc=2.
- HALT at pc=4 → state=5, halted=1, pc=4. imem write in HALT is accepted; imem write during EXEC is ignored. rst → state=0, pc=0, halted=0.
- MUL r3,r1,r2 with r1=0x0100, r2=0x0100 → with PARAM_PROC_MUL_EN: alu_result=0, flags=101. Without: r3 unchanged. Assert rst mid-EXEC → r3 unchanged, all outputs at reset values.
